step_dispatch: RTL and testbench
================================

STEP_DISPATCH -- requirements
Module: step_dispatch

Interface
REQ-001 Parameter: TIMEOUT, default 8'd255, the number of WAIT cycles allowed without a step response before abort (used only when STEP_DISPATCH_TIMEOUT_EN is defined).
REQ-002 Port: clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 Port: rst_, input, 1, asynchronous active-low reset.
REQ-004 Port: ena_, input, 1, active-low start strobe from the upstream stage, sampled on the rising edge of clk.
REQ-005 Port: opcode, input, 4, step-unit select; sampled together with ena_.
REQ-006 Port: rdy_, output, 1, open-drain completion strobe to upstream; drives either 0 or Z.
REQ-007 Port: ex_ena_, output, 16, one-hot active-low strobes to the step units; push-pull; idle value 16'hFFFF.
REQ-008 Port: ex_rdy_, input, 1, wired step-unit ready line, pulled up externally; the block treats only a sampled 0 as "done".
REQ-009 Port: err_, output, 1, open-drain timeout flag; drives either 0 or Z.
REQ-010 Port: busy, output, 1, high whenever the state is not IDLE.

Function
REQ-011 The block SHALL implement the states IDLE, ISSUE, WAIT and DONE, held in a registered state variable.
REQ-012 In IDLE, when ena_ is sampled as 0, the block SHALL latch opcode into op_q, enter ISSUE, and drive ex_ena_[op_q]=0 with all other bits at 1.
REQ-013 ISSUE SHALL last exactly one cycle: ex_ena_ returns to 16'hFFFF on the next edge and the state moves to WAIT.
REQ-014 ex_rdy_ SHALL be ignored in IDLE, ISSUE and DONE; it is sampled only in WAIT.
REQ-015 In WAIT, when ex_rdy_ is sampled as 0, the block SHALL enter DONE and drive rdy_=0.
REQ-016 DONE SHALL last exactly one cycle: rdy_ returns to Z and the state moves to IDLE.
REQ-017 Latency: with ena_ sampled low at edge N and a compliant step unit (rdy_ low after edge N+2), rdy_ SHALL be 0 between edge N+3 and edge N+4.
REQ-018 A new ena_ low SHALL be accepted in IDLE only; ena_ held low in IDLE starts back-to-back operations (the next ISSUE starts one cycle after DONE).
REQ-019 ena_ and opcode changes SHALL be ignored in ISSUE, WAIT and DONE; op_q SHALL stay stable for the whole operation.
REQ-020 ex_ena_ SHALL never have more than one bit at 0, in any cycle.
REQ-021 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-022 While rst_=0: state=IDLE, op_q=0, ex_ena_=16'hFFFF, rdy_=Z, err_=Z, busy=0, and the timeout counter is 0.
REQ-023 Assertion of rst_ mid-operation SHALL immediately release all strobes, with no rdy_ pulse issued for the aborted operation.
REQ-024 The first ena_ SHALL be sampled on the first rising edge after rst_ deasserts.

Configuration
REQ-025 When STEP_DISPATCH_TIMEOUT_EN is defined:
- An 8-bit counter is cleared on entry to WAIT and increments each WAIT cycle.
- If the counter reaches TIMEOUT with ex_rdy_ still 1, the block enters DONE and drives rdy_=0 and err_=0 for that one cycle.
- If ex_rdy_=0 and the counter reaches TIMEOUT on the same edge, the completion wins and err_ stays Z.
REQ-026 When STEP_DISPATCH_TIMEOUT_EN is undefined: the block has no counter, WAIT persists until ex_rdy_=0, err_ is constant Z, and TIMEOUT is unused.

Verification
REQ-027 Basic: reset, then ena_=0 with opcode=4'h3 for one cycle, and a model unit answering after 2 edges -> ex_ena_=16'hFFF7 for one cycle, then rdy_=0 for one cycle at edge N+3, err_=Z.
REQ-028 Busy ignore: during WAIT, pulse ena_=0 with opcode=4'hA -> no change to ex_ena_, op_q stays 3, exactly one rdy_ pulse.
REQ-029 Back-to-back: ena_ held 0 with opcodes 4'h0 then 4'hF -> ex_ena_=16'hFFFE, then 16'h7FFF one cycle after DONE; two rdy_ pulses.
REQ-030 Stale ready: ex_rdy_ forced 0 during ISSUE only -> no early DONE; completion only on a WAIT-sampled 0.
REQ-031 Reset mid-WAIT: rst_=0 two cycles into WAIT -> ex_ena_=16'hFFFF, rdy_=Z, busy=0 at once; the next ena_ is accepted normally.
REQ-032 Timeout (macro defined, TIMEOUT=8'd4): no unit response -> rdy_=0 and err_=0 together, for one cycle, after 4 WAIT cycles. Macro undefined: busy stays 1 indefinitely and err_ stays Z.

Source files
------------

// File: rtl/step_dispatch.sv
// step_dispatch: issues a one-hot active-low strobe to one of 16 step units and returns an
// open-drain completion strobe. Optional WAIT timeout abort under STEP_DISPATCH_TIMEOUT_EN.
module step_dispatch #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        ena_,
    input  logic [3:0]  opcode,
    output logic        rdy_,
    output logic [15:0] ex_ena_,
    input  logic        ex_rdy_,
    output logic        err_,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_op_q;
    logic [3:0]  w_op_nxt;
    logic [15:0] r_ex_ena;
    logic [15:0] w_ex_ena_nxt;
    logic        r_rdy_drv;
    logic        w_rdy_nxt;
    logic        r_busy;

`ifdef STEP_DISPATCH_TIMEOUT_EN
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [7:0]  w_cnt_inc;
    logic        r_err_drv;
    logic        w_err_nxt;

    assign w_cnt_inc = r_cnt + 8'd1;
`else
    logic        w_timeout_unused;

    assign w_timeout_unused = ^TIMEOUT;
`endif

    // Next-state and next-output decode; outputs are computed one edge ahead and registered.
    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op_q;
        w_ex_ena_nxt = 16'hFFFF;
        w_rdy_nxt    = 1'b0;
`ifdef STEP_DISPATCH_TIMEOUT_EN
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!ena_) begin
                    w_state_nxt  = S_ISSUE;
                    w_op_nxt     = opcode;
                    w_ex_ena_nxt = 16'hFFFF ^ (16'd1 << opcode);
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
`ifdef STEP_DISPATCH_TIMEOUT_EN
                w_cnt_nxt   = 8'd0;
`endif
            end
            S_WAIT: begin
                if (!ex_rdy_) begin
                    w_state_nxt = S_DONE;
                    w_rdy_nxt   = 1'b1;
                end else begin
`ifdef STEP_DISPATCH_TIMEOUT_EN
                    // Completion has priority: timeout only considered when ex_rdy_ is high.
                    if (w_cnt_inc == TIMEOUT) begin
                        w_state_nxt = S_DONE;
                        w_rdy_nxt   = 1'b1;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                    w_cnt_nxt = w_cnt_inc;
`else
                    w_state_nxt = S_WAIT;
`endif
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, latched opcode and registered output drivers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state   <= S_IDLE;
            r_op_q    <= 4'd0;
            r_ex_ena  <= 16'hFFFF;
            r_rdy_drv <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_op_q    <= w_op_nxt;
            r_ex_ena  <= w_ex_ena_nxt;
            r_rdy_drv <= w_rdy_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

`ifdef STEP_DISPATCH_TIMEOUT_EN
    // WAIT-cycle counter and timeout flag driver.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_cnt     <= 8'd0;
            r_err_drv <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_err_drv <= w_err_nxt;
        end
    end

    assign err_ = r_err_drv ? 1'b0 : 1'bz;
`else
    assign err_ = 1'bz;
`endif

    assign rdy_    = r_rdy_drv ? 1'b0 : 1'bz;
    assign ex_ena_ = r_ex_ena;
    assign busy    = r_busy;

endmodule

// File: tb/tb_step_dispatch.sv
// Randomized + directed bench for step_dispatch against an operation-timeline reference model.
module tb_step_dispatch;

`ifdef STEP_DISPATCH_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_;
    logic        ena_;
    logic [3:0]  opcode;
    logic        ex_rdy_;
    wire         rdy_w;
    wire         err_w;
    logic [15:0] ex_ena_w;
    logic        busy_w;

    pullup (rdy_w);
    pullup (err_w);

    step_dispatch #(.TIMEOUT(8'd4)) dut (
        .clk     (clk),
        .rst_    (rst_),
        .ena_    (ena_),
        .opcode  (opcode),
        .rdy_    (rdy_w),
        .ex_ena_ (ex_ena_w),
        .ex_rdy_ (ex_rdy_),
        .err_    (err_w),
        .busy    (busy_w)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one operation described by its accept edge and its completion edge.
    bit         m_active;
    logic [3:0] m_op;
    int         m_start;
    int         m_done;
    int         m_k;
    bit         m_err;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_step(input logic e, input logic [3:0] op, input logic r);
        m_k++;
        if (!m_active) begin
            if (!e) begin
                m_active = 1'b1;
                m_op     = op;
                m_start  = m_k;
                m_done   = -1;
                m_err    = 1'b0;
            end
        end else if (m_done >= 0) begin
            m_active = 1'b0;
        end else if (m_k >= m_start + 2) begin
            if (!r) begin
                m_done = m_k;
            end else if (TMO_EN && (m_k - m_start - 1) == TMO) begin
                m_done = m_k;
                m_err  = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        logic [15:0] exp_ex;
        exp_ex = (m_active && m_k == m_start) ? ~(16'd1 << m_op) : 16'hFFFF;
        chk("ex_ena", ex_ena_w, exp_ex);
        chk("rdy", {15'd0, rdy_w}, {15'd0, (m_done == m_k) ? 1'b0 : 1'b1});
        chk("err", {15'd0, err_w}, {15'd0, (m_done == m_k && m_err) ? 1'b0 : 1'b1});
        chk("busy", {15'd0, busy_w}, {15'd0, m_active});
    endtask

    task automatic cyc(input logic e, input logic [3:0] op, input logic r);
        @(negedge clk);
        ena_ = e; opcode = op; ex_rdy_ = r;
        @(posedge clk);
        model_step(e, op, r);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ = 1'b0; ena_ = 1'b1; ex_rdy_ = 1'b1;
        m_active = 1'b0;
        m_done   = -1;
        #1;
        chk("rst_ex_ena", ex_ena_w, 16'hFFFF);
        chk("rst_rdy", {15'd0, rdy_w}, 16'd1);
        chk("rst_err", {15'd0, err_w}, 16'd1);
        chk("rst_busy", {15'd0, busy_w}, 16'd0);
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    initial begin
        rst_ = 1'b1; ena_ = 1'b1; opcode = 4'd0; ex_rdy_ = 1'b1;
        m_active = 1'b0; m_op = 4'd0; m_start = -10; m_done = -1; m_k = 0; m_err = 1'b0;
        do_reset();

        // Basic dispatch of opcode 3 with a unit answering after two edges.
        cyc(1'b0, 4'h3, 1'b1);
        chk("basic_issue", ex_ena_w, 16'hFFF7);
        cyc(1'b1, 4'h0, 1'b1);
        chk("basic_release", ex_ena_w, 16'hFFFF);
        cyc(1'b1, 4'h0, 1'b1);
        cyc(1'b1, 4'h0, 1'b0);
        chk("basic_rdy", {15'd0, rdy_w}, 16'd0);
        chk("basic_err", {15'd0, err_w}, 16'd1);
        cyc(1'b1, 4'h0, 1'b1);
        chk("basic_rdy_end", {15'd0, rdy_w}, 16'd1);

        // Start request during WAIT is ignored.
        cyc(1'b0, 4'h3, 1'b1);
        cyc(1'b1, 4'h3, 1'b1);
        cyc(1'b0, 4'hA, 1'b1);
        chk("busy_ignore", ex_ena_w, 16'hFFFF);
        cyc(1'b1, 4'h0, 1'b0);
        cyc(1'b1, 4'h0, 1'b1);
        cyc(1'b1, 4'h0, 1'b1);

        // Back-to-back with ena_ held low.
        cyc(1'b0, 4'h0, 1'b1);
        chk("b2b_first", ex_ena_w, 16'hFFFE);
        cyc(1'b0, 4'h5, 1'b1);
        cyc(1'b0, 4'h5, 1'b0);
        cyc(1'b0, 4'hF, 1'b1);
        cyc(1'b0, 4'hF, 1'b1);
        chk("b2b_second", ex_ena_w, 16'h7FFF);
        cyc(1'b1, 4'h0, 1'b1);
        cyc(1'b1, 4'h0, 1'b0);
        cyc(1'b1, 4'h0, 1'b1);

        // Stale ready during ISSUE must not complete the operation.
        cyc(1'b0, 4'h2, 1'b1);
        cyc(1'b1, 4'h0, 1'b0);
        chk("stale_rdy", {15'd0, rdy_w}, 16'd1);
        cyc(1'b1, 4'h0, 1'b1);
        chk("stale_busy", {15'd0, busy_w}, 16'd1);
        cyc(1'b1, 4'h0, 1'b0);
        cyc(1'b1, 4'h0, 1'b1);

        // Reset two cycles into WAIT, then a normal dispatch.
        cyc(1'b0, 4'h6, 1'b1);
        cyc(1'b1, 4'h0, 1'b1);
        cyc(1'b1, 4'h0, 1'b1);
        cyc(1'b1, 4'h0, 1'b1);
        do_reset();
        cyc(1'b0, 4'h9, 1'b1);
        chk("post_rst_issue", ex_ena_w, 16'hFDFF);
        cyc(1'b1, 4'h0, 1'b1);
        cyc(1'b1, 4'h0, 1'b0);
        cyc(1'b1, 4'h0, 1'b1);

        // Unit never answers: timeout abort or indefinite busy.
        cyc(1'b0, 4'h1, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 4'h0, 1'b1);
        do_reset();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else cyc($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
